mem_access_stage: RTL and testbench

- MEM stage of the 64-bit in-order pipeline. Sits between EX/MEM and MEM/WB.
- Takes load/store requests from EX/MEM and runs a request/ack transaction on the data-memory port. Aligns and extends load data, and presents registered results with a valid pulse to MEM/WB.
- Stalls upstream while a memory transaction is outstanding. Flags misaligned, illegal-size and timed-out accesses.

---
 rtl/mem_access_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit in-order pipeline: issues load/store transactions on the
// data-memory port, aligns/extends load data and presents registered results to MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_alu,
    input  logic [63:0] in_store_data,
    input  logic [63:0] in_pc4,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        out_valid,
    output logic [63:0] rd_data_out,
    output logic [63:0] alu_data_out,
    output logic [63:0] pc4_out,
    output logic [4:0]  rd_out,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [7:0]         dmem_wstrb_q, dmem_wstrb_d;
    logic [63:0]        dmem_wdata_q, dmem_wdata_d;
    logic [63:0]        cap_alu_q, cap_alu_d;
    logic [63:0]        cap_pc4_q, cap_pc4_d;
    logic [4:0]         cap_rd_q, cap_rd_d;
    logic               cap_regwrite_q, cap_regwrite_d;
    logic               cap_memtoreg_q, cap_memtoreg_d;
    logic [2:0]         cap_funct3_q, cap_funct3_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        rd_data_q, rd_data_d;
    logic [63:0]        alu_data_q, alu_data_d;
    logic [63:0]        pc4_q, pc4_d;
    logic [4:0]         rd_q, rd_d;
    logic               regwrite_q, regwrite_d;
    logic               memtoreg_q, memtoreg_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_cause_q, fault_cause_d;

    logic               mem_op, illegal, misaligned, timeout;
    logic [63:0]        store_rep, load_sh, load_ext;
    logic [7:0]         strb_base;

    // Request decode: size legality, alignment and lane-replicated store data
    always_comb begin
        mem_op     = in_memread | in_memwrite;
        illegal    = (in_memread & in_memwrite)
                   | (in_memread & (in_funct3 == 3'b111))
                   | (in_memwrite & in_funct3[2]);
        misaligned = 1'b0;
        store_rep  = in_store_data;
        strb_base  = 8'hFF;
        case (in_funct3[1:0])
            2'b00: begin
                store_rep = {8{in_store_data[7:0]}};
                strb_base = 8'h01;
            end
            2'b01: begin
                misaligned = in_alu[0];
                store_rep  = {4{in_store_data[15:0]}};
                strb_base  = 8'h03;
            end
            2'b10: begin
                misaligned = |in_alu[1:0];
                store_rep  = {2{in_store_data[31:0]}};
                strb_base  = 8'h0F;
            end
            default: misaligned = |in_alu[2:0];
        endcase
    end

    // Load return path: shift the addressed lane down, then truncate and extend
    always_comb begin
        load_sh  = dmem_rdata >> {cap_alu_q[2:0], 3'b000};
        load_ext = load_sh;
        case (cap_funct3_q)
            3'b000:  load_ext = {{56{load_sh[7]}},  load_sh[7:0]};
            3'b001:  load_ext = {{48{load_sh[15]}}, load_sh[15:0]};
            3'b010:  load_ext = {{32{load_sh[31]}}, load_sh[31:0]};
            3'b100:  load_ext = {56'd0, load_sh[7:0]};
            3'b101:  load_ext = {48'd0, load_sh[15:0]};
            3'b110:  load_ext = {32'd0, load_sh[31:0]};
            default: load_ext = load_sh;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_wstrb_d   = dmem_wstrb_q;
        dmem_wdata_d   = dmem_wdata_q;
        cap_alu_d      = cap_alu_q;
        cap_pc4_d      = cap_pc4_q;
        cap_rd_d       = cap_rd_q;
        cap_regwrite_d = cap_regwrite_q;
        cap_memtoreg_d = cap_memtoreg_q;
        cap_funct3_d   = cap_funct3_q;
        out_valid_d    = 1'b0;
        rd_data_d      = rd_data_q;
        alu_data_d     = alu_data_q;
        pc4_d          = pc4_q;
        rd_d           = rd_q;
        regwrite_d     = regwrite_q;
        memtoreg_d     = memtoreg_q;
        fault_d        = fault_q;
        fault_cause_d  = fault_cause_q;
        mem_stall      = 1'b0;
        timeout        = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (mem_op && !illegal && !misaligned) begin
                        mem_stall      = 1'b1;
                        state_d        = S_WAIT;
                        cnt_d          = '0;
                        dmem_req_d     = 1'b1;
                        dmem_we_d      = in_memwrite;
                        dmem_wstrb_d   = in_memwrite ? 8'(strb_base << in_alu[2:0]) : 8'h00;
                        dmem_wdata_d   = store_rep;
                        cap_alu_d      = in_alu;
                        cap_pc4_d      = in_pc4;
                        cap_rd_d       = in_rd;
                        cap_regwrite_d = in_regwrite;
                        cap_memtoreg_d = in_memtoreg;
                        cap_funct3_d   = in_funct3;
                    end else begin
                        // Non-memory op or faulting access completes in one cycle
                        out_valid_d   = 1'b1;
                        rd_data_d     = '0;
                        alu_data_d    = in_alu;
                        pc4_d         = in_pc4;
                        rd_d          = in_rd;
                        memtoreg_d    = in_memtoreg;
                        fault_d       = mem_op;
                        regwrite_d    = in_regwrite & !mem_op;
                        fault_cause_d = !mem_op ? 2'b00 : (illegal ? 2'b10 : 2'b01);
                    end
                end
            end
            S_WAIT: begin
                mem_stall = !dmem_ack && !timeout;
                if (dmem_ack || timeout) begin
                    state_d       = S_IDLE;
                    dmem_req_d    = 1'b0;
                    dmem_we_d     = 1'b0;
                    dmem_wstrb_d  = 8'h00;
                    out_valid_d   = 1'b1;
                    alu_data_d    = cap_alu_q;
                    pc4_d         = cap_pc4_q;
                    rd_d          = cap_rd_q;
                    memtoreg_d    = cap_memtoreg_q;
                    fault_d       = !dmem_ack;
                    fault_cause_d = dmem_ack ? 2'b00 : 2'b11;
                    regwrite_d    = cap_regwrite_q & dmem_ack;
                    rd_data_d     = (dmem_ack && !dmem_we_q) ? load_ext : 64'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_wstrb_q   <= '0;
            dmem_wdata_q   <= '0;
            cap_alu_q      <= '0;
            cap_pc4_q      <= '0;
            cap_rd_q       <= '0;
            cap_regwrite_q <= 1'b0;
            cap_memtoreg_q <= 1'b0;
            cap_funct3_q   <= '0;
            out_valid_q    <= 1'b0;
            rd_data_q      <= '0;
            alu_data_q     <= '0;
            pc4_q          <= '0;
            rd_q           <= '0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            fault_q        <= 1'b0;
            fault_cause_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_wstrb_q   <= dmem_wstrb_d;
            dmem_wdata_q   <= dmem_wdata_d;
            cap_alu_q      <= cap_alu_d;
            cap_pc4_q      <= cap_pc4_d;
            cap_rd_q       <= cap_rd_d;
            cap_regwrite_q <= cap_regwrite_d;
            cap_memtoreg_q <= cap_memtoreg_d;
            cap_funct3_q   <= cap_funct3_d;
            out_valid_q    <= out_valid_d;
            rd_data_q      <= rd_data_d;
            alu_data_q     <= alu_data_d;
            pc4_q          <= pc4_d;
            rd_q           <= rd_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            fault_q        <= fault_d;
            fault_cause_q  <= fault_cause_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = {cap_alu_q[63:3], 3'b000};
    assign dmem_wdata   = dmem_wdata_q;
    assign dmem_wstrb   = dmem_wstrb_q;
    assign out_valid    = out_valid_q;
    assign rd_data_out  = rd_data_q;
    assign alu_data_out = alu_data_q;
    assign pc4_out      = pc4_q;
    assign rd_out       = rd_q;
    assign regwrite_out = regwrite_q;
    assign memtoreg_out = memtoreg_q;
    assign fault_out    = fault_q;
    assign fault_cause  = fault_cause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): loads, stores, faults,
// timeout, back-to-back issue and reset during an outstanding transaction.
module tb_mem_access_stage;

    logic        clk, rst;
    logic        in_valid, in_memread, in_memwrite;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu, in_store_data, in_pc4;
    logic [4:0]  in_rd;
    logic        in_regwrite, in_memtoreg;
    logic        mem_stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        out_valid;
    logic [63:0] rd_data_out, alu_data_out, pc4_out;
    logic [4:0]  rd_out;
    logic        regwrite_out, memtoreg_out, fault_out;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_funct3(in_funct3), .in_alu(in_alu), .in_store_data(in_store_data),
        .in_pc4(in_pc4), .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .rd_data_out(rd_data_out), .alu_data_out(alu_data_out),
        .pc4_out(pc4_out), .rd_out(rd_out), .regwrite_out(regwrite_out),
        .memtoreg_out(memtoreg_out), .fault_out(fault_out), .fault_cause(fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_memread  = rd_en;
        in_memwrite = wr_en;
        in_funct3   = f3;
        in_alu      = addr;
        in_rd       = rd;
        in_pc4      = 64'h100 + addr;
        in_regwrite = 1'b1;
        in_memtoreg = rd_en;
    endtask

    // Load with ack in the first WAIT cycle
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        int stall_cycles;
        stall_cycles = 0;
        drive(1'b1, 1'b0, f3, addr, 5'd10);
        #1;
        if (mem_stall) stall_cycles++;
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        in_valid   = 1'b0;
        #1;
        if (mem_stall) stall_cycles++;
        check({tag, "_req"}, dmem_req, 1'b1);
        check({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        check({tag, "_ov_early"}, out_valid, 1'b0);
        tick();
        dmem_ack = 1'b0;
        check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd1);
        check({tag, "_ov"}, out_valid, 1'b1);
        check({tag, "_data"}, rd_data_out, exp);
        check({tag, "_fault"}, fault_out, 1'b0);
        check({tag, "_regwrite"}, regwrite_out, 1'b1);
        check({tag, "_rd"}, rd_out, 5'd10);
        check({tag, "_pc4"}, pc4_out, 64'h100 + addr);
        tick();
        check({tag, "_ov_drop"}, out_valid, 1'b0);
    endtask

    task automatic fault_case(input string tag, input logic rd_en, input logic wr_en,
                              input logic [2:0] f3, input logic [63:0] addr,
                              input logic [1:0] cause);
        drive(rd_en, wr_en, f3, addr, 5'd4);
        #1;
        check({tag, "_stall"}, mem_stall, 1'b0);
        tick();
        in_valid = 1'b0;
        check({tag, "_ov"}, out_valid, 1'b1);
        check({tag, "_fault"}, fault_out, 1'b1);
        check({tag, "_cause"}, fault_cause, cause);
        check({tag, "_regwrite"}, regwrite_out, 1'b0);
        check({tag, "_req"}, dmem_req, 1'b0);
        tick();
        check({tag, "_ov_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int req_cycles;
        rst = 1'b1;
        in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_funct3 = 3'd0;
        in_alu = '0; in_store_data = '0; in_pc4 = '0; in_rd = '0;
        in_regwrite = 1'b0; in_memtoreg = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_wstrb", dmem_wstrb, 8'h00);
        check("rst_data", rd_data_out, 64'd0);
        tick();
        rst = 1'b0;

        do_load("lb",  3'b000, 64'h1005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lh",  3'b001, 64'h1002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
        do_load("lhu", 3'b101, 64'h1002, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);
        do_load("lw",  3'b010, 64'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load("lwu", 3'b110, 64'h1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        do_load("lbu", 3'b100, 64'h1007, 64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE);

        // SH with ack in the third WAIT cycle
        drive(1'b0, 1'b1, 3'b001, 64'h2006, 5'd0);
        in_regwrite   = 1'b0;
        in_store_data = 64'hDEAD_BEEF_CAFE_1234;
        #1;
        check("sh_accept_stall", mem_stall, 1'b1);
        tick();
        check("sh_addr", dmem_addr, 64'h2000);
        check("sh_wstrb", dmem_wstrb, 8'hC0);
        check("sh_wdata", dmem_wdata, 64'h1234_1234_1234_1234);
        check("sh_we", dmem_we, 1'b1);
        check("sh_stall_w1", mem_stall, 1'b1);
        tick();
        check("sh_stall_w2", mem_stall, 1'b1);
        tick();
        dmem_ack = 1'b1;
        in_valid = 1'b0;
        #1;
        check("sh_stall_w3", mem_stall, 1'b0);
        check("sh_wdata_hold", dmem_wdata, 64'h1234_1234_1234_1234);
        tick();
        dmem_ack = 1'b0;
        check("sh_ov", out_valid, 1'b1);
        check("sh_data", rd_data_out, 64'd0);
        check("sh_we_clr", dmem_we, 1'b0);
        tick();
        check("sh_ov_once", out_valid, 1'b0);

        fault_case("f_lw_mis", 1'b1, 1'b0, 3'b010, 64'h3002, 2'b01);
        fault_case("f_lh_mis", 1'b1, 1'b0, 3'b001, 64'h3001, 2'b01);
        fault_case("f_sd_mis", 1'b0, 1'b1, 3'b011, 64'h3004, 2'b01);
        fault_case("f_ld111",  1'b1, 1'b0, 3'b111, 64'h3000, 2'b10);
        fault_case("f_st100",  1'b0, 1'b1, 3'b100, 64'h3003, 2'b10);
        fault_case("f_rdwr",   1'b1, 1'b1, 3'b000, 64'h3000, 2'b10);

        // LD with no ack: five WAIT cycles, then timeout fault
        drive(1'b1, 1'b0, 3'b011, 64'h48, 5'd6);
        #1;
        check("to_accept_stall", mem_stall, 1'b1);
        tick();
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (dmem_req) req_cycles++;
            check("to_stall", mem_stall, (i == 4) ? 1'b0 : 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 3'b000, 64'h99, 5'd3);
        #1;
        check("to_req_cycles", 64'(req_cycles), 64'd5);
        check("to_ov", out_valid, 1'b1);
        check("to_cause", fault_cause, 2'b11);
        check("to_fault", fault_out, 1'b1);
        check("to_regwrite", regwrite_out, 1'b0);
        check("to_req_clr", dmem_req, 1'b0);
        check("to_next_stall", mem_stall, 1'b0);
        tick();
        in_valid = 1'b0;
        check("to_next_ov", out_valid, 1'b1);
        check("to_next_alu", alu_data_out, 64'h99);
        check("to_next_fault", fault_out, 1'b0);

        // Back-to-back LD then ADD
        tick();
        drive(1'b1, 1'b0, 3'b011, 64'h40, 5'd7);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1122_3344_5566_7788;
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 64'hAB, 5'd9);
        in_memtoreg = 1'b0;
        check("b2b_ld_ov", out_valid, 1'b1);
        check("b2b_ld_data", rd_data_out, 64'h1122_3344_5566_7788);
        check("b2b_ld_rd", rd_out, 5'd7);
        check("b2b_ld_pc4", pc4_out, 64'h140);
        check("b2b_ld_m2r", memtoreg_out, 1'b1);
        tick();
        in_valid = 1'b0;
        check("b2b_add_ov", out_valid, 1'b1);
        check("b2b_add_alu", alu_data_out, 64'hAB);
        check("b2b_add_rd", rd_out, 5'd9);
        check("b2b_add_pc4", pc4_out, 64'h1AB);
        check("b2b_add_data", rd_data_out, 64'd0);
        check("b2b_add_m2r", memtoreg_out, 1'b0);

        // Reset in the second WAIT cycle, then a late ack
        tick();
        drive(1'b1, 1'b0, 3'b011, 64'h80, 5'd12);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rw_req", dmem_req, 1'b0);
        check("rw_ov", out_valid, 1'b0);
        check("rw_alu", alu_data_out, 64'd0);
        check("rw_pc4", pc4_out, 64'd0);
        check("rw_rd", rd_out, 5'd0);
        check("rw_ctrl", {regwrite_out, memtoreg_out, fault_out, fault_cause}, 5'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = '1;
        in_valid   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rw_late_ack_ov", out_valid, 1'b0);
        check("rw_late_ack_req", dmem_req, 1'b0);
        check("rw_idle_stall", mem_stall, 1'b0);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 64'h55, 5'd1);
        tick();
        in_valid = 1'b0;
        check("rw_idle_ov", out_valid, 1'b1);
        check("rw_idle_alu", alu_data_out, 64'h55);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
